// File: rtl/fifod2mac_pkg.sv
// Shared definitions for the flag-handshake transfer blocks (fifod2mac, mac2fifoc).
// Holds the state encoding and the default payload limits.
package fifod2mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WORK  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         MAX_LEN_DEFAULT  = 1472;
    localparam logic [7:0] PAD_BYTE_DEFAULT = 8'h00;
    localparam int         TIMEOUT_DEFAULT  = 4096;

endpackage

// File: rtl/fifod2mac.sv
// Drains exactly len bytes from the ADC data FIFO into the MAC UDP byte stream,
// padding over-requests and aborting with a sticky err when the MAC goes quiet.
module fifod2mac
    import fifod2mac_pkg::*;
#(
    parameter int         LEN_W    = 12,
    parameter int         MAX_LEN  = MAX_LEN_DEFAULT,
    parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT,
    parameter int         TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fs,
    output logic             fd,
    output logic             err,
    input  logic [LEN_W-1:0] tx_len,
    input  logic             udp_txen,
    output logic [7:0]       udp_txd,
    output logic             fifod_rxen,
    input  logic [7:0]       fifod_rxd
);

    localparam int               TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic [TO_W-1:0]  to_reg, to_next;
    logic             err_reg, err_next;
    logic             fd_reg;
    logic             rd_d1_reg;
    logic [LEN_W-1:0] len_clamped;

    assign len_clamped = (tx_len > MAX_LEN_L) ? MAX_LEN_L : tx_len;

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        to_next    = to_reg;
        err_next   = err_reg;
        fifod_rxen = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fs) begin
                    len_next   = len_clamped;
                    cnt_next   = '0;
                    to_next    = '0;
                    err_next   = 1'b0;
                    state_next = (len_clamped == '0) ? DRAIN : WORK;
                end
            end
            WORK: begin
                fifod_rxen = udp_txen && (cnt_reg < len_reg);
                if (fifod_rxen)
                    cnt_next = cnt_reg + LEN_W'(1);
                // A request on the threshold cycle wins over the timeout.
                if (udp_txen)
                    to_next = '0;
                else
                    to_next = to_reg + TO_W'(1);
                if (cnt_reg == len_reg) begin
                    state_next = DRAIN;
                end else if (!udp_txen && (to_reg == TO_LAST)) begin
                    err_next   = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!udp_txen)
                    state_next = DONE;
            end
            DONE: begin
                if (!fs)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            len_reg   <= '0;
            cnt_reg   <= '0;
            to_reg    <= '0;
            err_reg   <= 1'b0;
            fd_reg    <= 1'b0;
            rd_d1_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            to_reg    <= to_next;
            err_reg   <= err_next;
            fd_reg    <= (state_next == DONE);
            rd_d1_reg <= fifod_rxen;
        end
    end

    // FIFO data arrives one cycle after the read, lining up with rd_d1_reg.
    assign udp_txd = rd_d1_reg ? fifod_rxd : PAD_BYTE;
    assign fd      = fd_reg;
    assign err     = err_reg;

endmodule

// File: doc/fifod2mac.md
Name: fifod2mac

Overview:
- Transmit-side bridge: drains the ADC data FIFO (fifod, read port) into the MAC UDP transmit byte stream (udp_txd), in the gmii_txc domain.
- Started and finished by cs through the fs/fd flag pair.
- Delivers exactly tx_len payload bytes per frame. It pads if the MAC pulls more bytes than that, and flags an error if the MAC stalls.

Parameters:
- LEN_W, 12, width of tx_len and of the byte counter.
- MAX_LEN, 1472, maximum UDP payload bytes; a larger tx_len is clamped to this.
- PAD_BYTE, 8'h00, value driven on udp_txd for bytes requested beyond tx_len.
- TIMEOUT, 4096, idle cycles allowed in WORK without udp_txen before err is raised.

Ports:
- clk  in  1  transmit byte clock (gmii_txc).
- rst  in  1  asynchronous, active-high reset.
- fs  in  1  start level from cs; held high until fd is seen.
- fd  out  1  done level to cs; held high until fs drops.
- err  out  1  sticky timeout error; cleared by rst or by the next accepted fs.
- tx_len  in  LEN_W  payload length in bytes; sampled on fs acceptance.
- udp_txen  in  1  MAC byte request; one byte per cycle while high.
- udp_txd  out  8  payload byte; valid one cycle after the matching udp_txen.
- fifod_rxen  out  1  fifod read enable.
- fifod_rxd  in  8  fifod read data; standard FIFO, one-cycle read latency.

Behaviour:
- Reset (async, active-high): state=IDLE; fd=0, err=0, fifod_rxen=0, udp_txd=PAD_BYTE; counters=0.
- States: IDLE, WORK, DRAIN, DONE.
- IDLE:
  - On fs=1: latch len=min(tx_len, MAX_LEN), clear cnt, clear timeout counter and err.
  - If len=0 go to DRAIN, otherwise go to WORK.
- WORK:
  - Read rule: fifod_rxen = udp_txen AND (cnt < len), combinational.
  - cnt increments on every cycle with fifod_rxen=1.
  - Register rd_d1 <= fifod_rxen.
  - Data mux: udp_txd = rd_d1 ? fifod_rxd : PAD_BYTE.
  - Over-request: a udp_txen cycle with cnt >= len does not read the FIFO; it produces PAD_BYTE on the next cycle.
  - Leave WORK for DRAIN when cnt reaches len, i.e. the cycle after the last read.
  - Timeout counter: reset on any udp_txen=1 cycle, otherwise increments. When it reaches TIMEOUT: set err=1 and go to DRAIN (abort). No further FIFO reads; fifod contents are left as they are (cs resets fifod).
- DRAIN:
  - Waits for udp_txen=0, so the MAC has finished pulling bytes. Any requests seen here return PAD_BYTE.
  - Then go to DONE.
- DONE:
  - fd=1 (registered).
  - Leave for IDLE when fs=0; fd drops on the same edge.
- fs behaviour outside IDLE:
  - fs falling while in WORK or DRAIN is ignored; the transaction completes normally.
  - fs held high in IDLE after DONE cannot happen, because DONE requires fs=0 before returning to IDLE.
- Simultaneous udp_txen and the timeout threshold: udp_txen wins; the counter is cleared and there is no error.
- FIFO empty is not visible to this block. cs guarantees that fifod holds at least len bytes before raising fs.
- Counter widths: cnt is LEN_W bits. It cannot wrap, because len ≤ MAX_LEN < 2^LEN_W.
- Latency:
  - fs to first possible fifod_rxen: 1 cycle.
  - udp_txen to udp_txd: 1 cycle.
  - Last requested byte to fd: at most 2 cycles after udp_txen falls.

Decomposition:
- Shared package for flag/transfer blocks: state encodings (IDLE/WORK/DRAIN/DONE), MAX_LEN, PAD_BYTE.
- No sub-module needed. The timeout counter is inline; it may later be split out as a generic flag_timeout block shared with mac2fifoc.

Test Plan:
- Basic frame: fifod preloaded 0x00..0x0F, tx_len=16, fs=1, then udp_txen held for 16 cycles → udp_txd=0x00..0x0F, 16 fifod_rxen pulses, fd=1 after udp_txen falls, fd=0 one edge after fs drops.
- Over-request: tx_len=4, fifod=A1 A2 A3 A4, udp_txen held for 6 cycles → udp_txd=A1 A2 A3 A4 00 00; exactly 4 reads; err=0.
- Zero/clamp: tx_len=0 → no reads, fd=1 within 3 cycles of fs. tx_len=2000 → exactly 1472 reads.
- Gapped requests: tx_len=8, udp_txen 1-0-1-0 pattern → data in order, no bytes lost or duplicated; byte N appears one cycle after the N-th udp_txen.
- Timeout: TIMEOUT=16, tx_len=10, 3 bytes pulled, then udp_txen=0 for 16 cycles → err=1, fd=1, no further reads. Next fs → err cleared.
- Reset mid-frame: rst asserted after 5 of 10 bytes → immediate IDLE, fd=0, fifod_rxen=0, udp_txd=0x00; a fresh fs after release runs normally.
